// File: rtl/dmem_arbiter.sv
// dmem_arbiter: per-cycle arbiter sharing single-port dmem between the CPU load/store port
// and VGA burst reads. Define ARB_CPU_PREEMPT_EN to let CPU accesses steal burst slots.
module dmem_arbiter #(
  parameter int AW   = 16,
  parameter int DW   = 32,
  parameter int LENW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cpu_req,
  input  logic            cpu_we,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_wdata,
  output logic            cpu_gnt,
  output logic            cpu_rvalid,
  output logic [DW-1:0]   cpu_rdata,
  input  logic            vga_req,
  input  logic [AW-1:0]   vga_addr,
  input  logic [LENW-1:0] vga_len,
  output logic            vga_gnt,
  output logic            vga_rvalid,
  output logic [DW-1:0]   vga_rdata,
  output logic            vga_done,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

`ifdef ARB_CPU_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_q, state_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic [AW-1:0]   baddr_q, baddr_d;
  logic [AW-1:0]   addr_hold_q;
  logic            last_vga_q, last_vga_d;
  logic            tag_cpu_q, tag_cpu_d;
  logic            tag_vga_q, tag_vga_d;
  logic            tag_last_q, tag_last_d;
  logic            cpu_wins;
  logic            issue_cpu;
  logic            issue_vga;

  // On a tie the CPU wins only if VGA was the most recent winner.
  assign cpu_wins = cpu_req & (~vga_req | last_vga_q);

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    baddr_d    = baddr_q;
    last_vga_d = last_vga_q;
    tag_cpu_d  = 1'b0;
    tag_vga_d  = 1'b0;
    tag_last_d = 1'b0;
    issue_cpu  = 1'b0;
    issue_vga  = 1'b0;
    cpu_gnt    = 1'b0;
    vga_gnt    = 1'b0;
    mem_addr   = addr_hold_q;
    mem_we     = 1'b0;
    mem_wdata  = '0;

    unique case (state_q)
      IDLE: begin
        if (cpu_wins) begin
          issue_cpu = 1'b1;
        end else if (vga_req) begin
          vga_gnt    = 1'b1;
          last_vga_d = 1'b1;
          baddr_d    = vga_addr;
          rem_d      = vga_len;
          // A zero-length burst only reports completion on the following cycle.
          if (vga_len == '0) tag_last_d = 1'b1;
          else               state_d    = BURST;
        end
      end
      BURST: begin
        if (PREEMPT && cpu_req) issue_cpu = 1'b1;
        else                    issue_vga = 1'b1;
      end
    endcase

    if (issue_cpu) begin
      cpu_gnt    = 1'b1;
      mem_addr   = cpu_addr;
      mem_we     = cpu_we;
      mem_wdata  = cpu_wdata;
      tag_cpu_d  = ~cpu_we;
      last_vga_d = 1'b0;
    end

    if (issue_vga) begin
      mem_addr  = baddr_q;
      tag_vga_d = 1'b1;
      baddr_d   = baddr_q + AW'(1);
      rem_d     = rem_q - LENW'(1);
      if (rem_q == LENW'(1)) begin
        tag_last_d = 1'b1;
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      baddr_q     <= '0;
      addr_hold_q <= '0;
      last_vga_q  <= 1'b1;
      tag_cpu_q   <= 1'b0;
      tag_vga_q   <= 1'b0;
      tag_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      baddr_q     <= baddr_d;
      addr_hold_q <= mem_addr;
      last_vga_q  <= last_vga_d;
      tag_cpu_q   <= tag_cpu_d;
      tag_vga_q   <= tag_vga_d;
      tag_last_q  <= tag_last_d;
    end
  end

  assign cpu_rvalid = tag_cpu_q;
  assign vga_rvalid = tag_vga_q;
  assign vga_done   = tag_last_q;
  assign cpu_rdata  = mem_rdata;
  assign vga_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized self-checking bench for dmem_arbiter with a one-cycle dmem model.
// Expected schedules are derived from grant/issue cycle arithmetic and a shadow memory.
module tb_dmem_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int LENW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cpu_req, cpu_we;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic            cpu_gnt, cpu_rvalid;
  logic [DW-1:0]   cpu_rdata;
  logic            vga_req;
  logic [AW-1:0]   vga_addr;
  logic [LENW-1:0] vga_len;
  logic            vga_gnt, vga_rvalid, vga_done;
  logic [DW-1:0]   vga_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;

  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .LENW(LENW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_len(vga_len),
    .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata), .vga_done(vga_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  function automatic logic [DW-1:0] init_word(input int unsigned a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ a;
  endfunction

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0; vga_len = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    checks++; if ({cpu_gnt, vga_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", {cpu_gnt, vga_gnt}); end
    checks++; if ({cpu_rvalid, vga_rvalid, vga_done} !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b expected 000", {cpu_rvalid, vga_rvalid, vga_done}); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    checks++; if (cpu_rdata !== mem_rdata || vga_rdata !== mem_rdata) begin errors++; $display("FAIL reset_rdata: got %h/%h expected %h", cpu_rdata, vga_rdata, mem_rdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_rw();
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d, exp_d;
    int unsigned   gap;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 32'h1234_5678;
    #1;
    checks++; if ({cpu_gnt, vga_gnt, mem_we} !== 3'b101) begin errors++; $display("FAIL wr_gnt: got %b expected 101", {cpu_gnt, vga_gnt, mem_we}); end
    checks++; if (mem_addr !== 16'h0010 || mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL wr_bus: got %h/%h expected 0010/12345678", mem_addr, mem_wdata); end
    ref_mem[16'h0010] = 32'h1234_5678;
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got %b expected 0", cpu_rvalid); end
    checks++; if ({mem_we, mem_wdata} !== 33'b0 || mem_addr !== 16'h0010) begin errors++; $display("FAIL idle_bus: got we=%b wd=%h a=%h expected 0/0/0010", mem_we, mem_wdata, mem_addr); end
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    #1;
    checks++; if ({cpu_gnt, mem_we} !== 2'b10 || mem_addr !== 16'h0010) begin errors++; $display("FAIL rd_gnt: got %b a=%h expected 10 a=0010", {cpu_gnt, mem_we}, mem_addr); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got v=%b d=%h expected 1/12345678", cpu_rvalid, cpu_rdata); end
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = 16'h0200 + 16'($urandom_range(0, 7));
      d  = $urandom;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      #1;
      checks++; if (cpu_gnt !== 1'b1 || mem_addr !== a || mem_we !== we) begin errors++; $display("FAIL rnd_cpu_issue: got g=%b a=%h we=%b expected 1/%h/%b", cpu_gnt, mem_addr, mem_we, a, we); end
      if (we) ref_mem[a] = d;
      exp_d = ref_mem[a];
      @(negedge clk);
      idle_inputs();
      #1;
      checks++; if (cpu_rvalid !== !we) begin errors++; $display("FAIL rnd_cpu_rvalid: got %b expected %b", cpu_rvalid, !we); end
      if (!we) begin
        checks++; if (cpu_rdata !== exp_d) begin errors++; $display("FAIL rnd_cpu_rdata: got %h expected %h", cpu_rdata, exp_d); end
      end
      @(negedge clk);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic run_burst(input logic [AW-1:0] a, input int unsigned n);
    logic [AW-1:0] ea;
    logic          exp_rv, exp_done;
    vga_req = 1'b1; vga_addr = a; vga_len = 8'(n);
    #1;
    checks++; if ({vga_gnt, cpu_gnt, mem_we} !== 3'b100) begin errors++; $display("FAIL burst_gnt: got %b expected 100", {vga_gnt, cpu_gnt, mem_we}); end
    @(negedge clk);
    for (int unsigned k = 1; k <= n + 1; k++) begin
      vga_req  = (k <= n);
      vga_addr = 16'($urandom);
      vga_len  = 8'($urandom);
      #1;
      exp_rv   = (k >= 2);
      exp_done = (k == n + 1);
      checks++; if ({vga_gnt, vga_rvalid, vga_done} !== {1'b0, exp_rv, exp_done}) begin errors++; $display("FAIL burst_flags k=%0d: got %b expected %b", k, {vga_gnt, vga_rvalid, vga_done}, {1'b0, exp_rv, exp_done}); end
      if (k <= n) begin
        ea = a + 16'(k - 1);
        checks++; if (mem_addr !== ea || mem_we !== 1'b0) begin errors++; $display("FAIL burst_addr k=%0d: got %h we=%b expected %h we=0", k, mem_addr, mem_we, ea); end
      end
      if (exp_rv) begin
        ea = a + 16'(k - 2);
        checks++; if (vga_rdata !== ref_mem[ea]) begin errors++; $display("FAIL burst_data k=%0d: got %h expected %h", k, vga_rdata, ref_mem[ea]); end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_burst();
    run_burst(16'h0100, 4);
  endtask

  task automatic test_wrap();
    run_burst(16'hFFFE, 4);
  endtask

  task automatic test_random_bursts();
    logic [AW-1:0] a;
    for (int i = 0; i < 6; i++) begin
      a = ($urandom_range(0, 1) == 1) ? 16'hFFF8 + 16'($urandom_range(0, 7)) : 16'($urandom);
      run_burst(a, $urandom_range(0, 12));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_tie();
    logic          last_vga, want_c, want_v, exp_c, exp_v, prev_c, prev_v;
    logic [AW-1:0] prev_a, a;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    last_vga = 1'b1;
    prev_c = 1'b0; prev_v = 1'b0; prev_a = '0;
    for (int i = 0; i < 30; i++) begin
      want_c = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      want_v = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
      a = 16'($urandom);
      cpu_req = want_c; cpu_we = 1'b0; cpu_addr = a;
      vga_req = want_v; vga_addr = 16'($urandom); vga_len = '0;
      exp_c = want_c & (~want_v | last_vga);
      exp_v = want_v & ~exp_c;
      #1;
      checks++; if ({cpu_gnt, vga_gnt} !== {exp_c, exp_v}) begin errors++; $display("FAIL tie_gnt i=%0d: got %b expected %b", i, {cpu_gnt, vga_gnt}, {exp_c, exp_v}); end
      checks++; if ({cpu_rvalid, vga_rvalid, vga_done} !== {prev_c, 1'b0, prev_v}) begin errors++; $display("FAIL tie_return i=%0d: got %b expected %b", i, {cpu_rvalid, vga_rvalid, vga_done}, {prev_c, 1'b0, prev_v}); end
      if (prev_c) begin
        checks++; if (cpu_rdata !== ref_mem[prev_a]) begin errors++; $display("FAIL tie_rdata i=%0d: got %h expected %h", i, cpu_rdata, ref_mem[prev_a]); end
      end
      if (exp_c) last_vga = 1'b0;
      if (exp_v) last_vga = 1'b1;
      prev_c = exp_c; prev_v = exp_v; prev_a = a;
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic cpu_in_burst(input logic [AW-1:0] a, input int n, input int cj);
    int            issue_idx [0:31];
    int            ret_idx   [0:31];
    int            cpu_c, last_c, c, kmax;
    logic [AW-1:0] ca, ea;
    logic          exp_g, exp_rv, exp_done, exp_crv;
    for (int k = 0; k < 32; k++) begin issue_idx[k] = -1; ret_idx[k] = -1; end
`ifdef ARB_CPU_PREEMPT_EN
    cpu_c = cj;
`else
    cpu_c = n + 1;
`endif
    last_c = 0;
    for (int i = 0; i < n; i++) begin
      c = 1 + i;
`ifdef ARB_CPU_PREEMPT_EN
      if (c >= cj) c = c + 1;
`endif
      issue_idx[c] = i;
      ret_idx[c + 1] = i;
      last_c = c;
    end
    kmax = ((cpu_c > last_c) ? cpu_c : last_c) + 1;
    ca = 16'($urandom);
    vga_req = 1'b1; vga_addr = a; vga_len = 8'(n);
    #1;
    checks++; if (vga_gnt !== 1'b1) begin errors++; $display("FAIL cib_vga_gnt: got %b expected 1", vga_gnt); end
    @(negedge clk);
    vga_req = 1'b0;
    for (int k = 1; k <= kmax; k++) begin
      cpu_req = (k >= cj) && (k <= cpu_c); cpu_we = 1'b0; cpu_addr = ca;
      #1;
      exp_g    = (k == cpu_c);
      exp_rv   = (ret_idx[k] >= 0);
      exp_done = (k == last_c + 1);
      exp_crv  = (k == cpu_c + 1);
      checks++; if ({cpu_gnt, vga_rvalid, vga_done, cpu_rvalid} !== {exp_g, exp_rv, exp_done, exp_crv}) begin errors++; $display("FAIL cib_flags k=%0d: got %b expected %b", k, {cpu_gnt, vga_rvalid, vga_done, cpu_rvalid}, {exp_g, exp_rv, exp_done, exp_crv}); end
      if (exp_g) begin
        checks++; if (mem_addr !== ca) begin errors++; $display("FAIL cib_cpu_addr k=%0d: got %h expected %h", k, mem_addr, ca); end
      end else if (issue_idx[k] >= 0) begin
        ea = a + 16'(issue_idx[k]);
        checks++; if (mem_addr !== ea) begin errors++; $display("FAIL cib_burst_addr k=%0d: got %h expected %h", k, mem_addr, ea); end
      end
      if (exp_rv) begin
        ea = a + 16'(ret_idx[k]);
        checks++; if (vga_rdata !== ref_mem[ea]) begin errors++; $display("FAIL cib_vga_data k=%0d: got %h expected %h", k, vga_rdata, ref_mem[ea]); end
      end
      if (exp_crv) begin
        checks++; if (cpu_rdata !== ref_mem[ca]) begin errors++; $display("FAIL cib_cpu_data k=%0d: got %h expected %h", k, cpu_rdata, ref_mem[ca]); end
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_cpu_during_burst();
    int n;
    cpu_in_burst(16'($urandom), 8, 2);
    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(1, 10);
      cpu_in_burst(16'($urandom), n, $urandom_range(1, n));
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [AW-1:0] a;
    a = 16'($urandom);
    vga_req = 1'b1; vga_addr = a; vga_len = 8'd8;
    #1;
    checks++; if (vga_gnt !== 1'b1) begin errors++; $display("FAIL rmb_gnt: got %b expected 1", vga_gnt); end
    @(negedge clk);
    vga_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++; if (mem_addr !== a + 16'(k - 1)) begin errors++; $display("FAIL rmb_addr k=%0d: got %h expected %h", k, mem_addr, a + 16'(k - 1)); end
      @(negedge clk);
    end
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if ({vga_rvalid, vga_done, mem_we} !== 3'b000 || mem_addr !== 16'h0000) begin errors++; $display("FAIL rmb_in_reset: got %b a=%h expected 000 a=0000", {vga_rvalid, vga_done, mem_we}, mem_addr); end
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++; if ({vga_rvalid, vga_done, cpu_rvalid, mem_we} !== 4'b0000) begin errors++; $display("FAIL rmb_after: got %b expected 0000", {vga_rvalid, vga_done, cpu_rvalid, mem_we}); end
      @(negedge clk);
    end
    vga_req = 1'b1; vga_addr = 16'($urandom); vga_len = '0;
    #1;
    checks++; if ({vga_gnt, mem_we} !== 2'b10 || mem_addr !== 16'h0000) begin errors++; $display("FAIL rmb_zero_gnt: got %b a=%h expected 10 a=0000", {vga_gnt, mem_we}, mem_addr); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if ({vga_done, vga_rvalid, mem_we} !== 3'b100 || mem_addr !== 16'h0000) begin errors++; $display("FAIL rmb_zero_done: got %b a=%h expected 100 a=0000", {vga_done, vga_rvalid, mem_we}, mem_addr); end
    @(negedge clk);
    #1;
    checks++; if (vga_done !== 1'b0) begin errors++; $display("FAIL rmb_done_pulse: got %b expected 0", vga_done); end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    test_reset();
    test_cpu_rw();
    test_burst();
    test_wrap();
    test_random_bursts();
    test_tie();
    test_cpu_during_burst();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory (`dmem`) between the MIPS core's load/store port and a VGA scanout fetcher that reads framebuffer words in bursts. It sits between `mipse`/VGA line fetcher and `dmem` in the DE0 top level. It arbitrates per cycle, generates burst addresses, and steers the one-cycle-latency read data back to the correct requester with valid strobes.

## Interface
- `AW`, 16, word address width (matches `dmem` address)
- `DW`, 32, data width
- `LENW`, 8, burst length counter width
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `cpu_req`  in  1  CPU access request, held until granted
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  AW  CPU word address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_gnt`  out  1  access issued to memory this cycle (combinational)
- `cpu_rvalid`  out  1  read data valid (reads only)
- `cpu_rdata`  out  DW  read data
- `vga_req`  in  1  burst request, held until granted
- `vga_addr`  in  AW  burst start word address
- `vga_len`  in  LENW  burst length in words
- `vga_gnt`  out  1  burst accepted (one-cycle pulse, combinational)
- `vga_rvalid`  out  1  one burst word valid
- `vga_rdata`  out  DW  burst word
- `vga_done`  out  1  pulses with last `vga_rvalid` of a burst
- `mem_addr`  out  AW  to `dmem` address
- `mem_we`  out  1  to `dmem` write enable
- `mem_wdata`  out  DW  to `dmem` data in
- `mem_rdata`  in  DW  from `dmem`, valid 1 cycle after address

## Operation
- FSM states: IDLE, BURST. Reset → IDLE; remaining count, burst address, last-winner flag and return tags cleared.
- IDLE, only `cpu_req`: `cpu_gnt`=1, drive `mem_addr`=`cpu_addr`, `mem_we`=`cpu_we`, `mem_wdata`=`cpu_wdata`.
- IDLE, only `vga_req`: `vga_gnt`=1, latch `vga_addr`/`vga_len`, go BURST; no memory access in the grant cycle.
- IDLE, both: the requester not served most recently wins (last-winner flag; reset value = VGA, so CPU wins the first tie).
- `vga_len`=0: `vga_gnt` pulses and `vga_done` pulses next cycle with `vga_rvalid`=0; stays IDLE.
- BURST: each slot issues a read at the burst address, increments the address modulo 2^AW and decrements remaining. After issuing the last word → IDLE. `vga_req` is ignored in BURST.
- CPU during BURST: see Configuration.
- Return path: registered tag {cpu, vga, last} records who issued a read. The next cycle asserts the tagged `*_rvalid`; `*_rdata`=`mem_rdata` combinationally. CPU writes produce no `cpu_rvalid`.
- Idle bus: `mem_we`=0, `mem_addr` holds its last value, `mem_wdata`=0.

## Timing
- Reset values: all gnt/rvalid/done 0, `mem_we` 0, `mem_addr` 0, `*_rdata` reflect `mem_rdata`.
- CPU read latency: `cpu_rvalid` exactly 1 cycle after `cpu_gnt`.
- Burst of N words, no interference: `vga_gnt` at T, words issued T+1..T+N, `vga_rvalid` T+2..T+N+1, `vga_done` at T+N+1. A new request can be granted at T+N+1.
- At most one memory access per cycle; `cpu_gnt` and a burst slot are never issued in the same cycle.
- Reset mid-burst: burst aborted immediately, no further `vga_rvalid`/`vga_done`, and any pending return tag is dropped.

## Configuration
- `ARB_CPU_PREEMPT_EN` defined: in BURST, if `cpu_req`=1, the CPU takes that cycle's slot (`cpu_gnt`=1). The burst pauses with address and count unchanged and resumes the next cycle. The CPU waits at most 1 cycle, and the burst is stretched by one cycle per CPU access.
- Not defined: the CPU waits until the burst completes, so worst-case CPU wait is 2^LENW cycles. The CPU is granted in the first IDLE cycle (tie-break still applies to a simultaneous new `vga_req`).

## Test plan
- After reset, CPU write 0x1234_5678 to addr 0x0010, then read 0x0010 → `cpu_gnt` same cycle, `cpu_rvalid` 1 cycle later with 0x1234_5678; no `cpu_rvalid` for the write.
- VGA burst `vga_addr`=0x0100, `vga_len`=4 over preloaded data → 4 consecutive `vga_rvalid` with words 0x100..0x103, and `vga_done` with the 4th.
- Wrap: `vga_addr`=0xFFFE, `vga_len`=4 → reads 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- `cpu_req` and `vga_req` both asserted out of reset → CPU granted first, VGA next cycle; repeated simultaneous requests alternate.
- `cpu_req` at burst word 2 of 8: with `ARB_CPU_PREEMPT_EN`, `cpu_gnt` next slot, and `vga_done` one cycle later than nominal. Without it, `cpu_gnt` in the cycle after the burst's last issue.
- `rst_n` low mid-burst (word 3 of 8) → no further `vga_rvalid`/`vga_done`; after release, a fresh `vga_len`=0 request yields `vga_gnt` then `vga_done` with no memory access.
